// File: rtl/arm_isa_pkg.sv
// arm_isa_pkg: shared ARM-subset ISA definitions for the instruction encoder.
//   op_e        - instruction class carried on in_op (DP, MEM, B)
//   CMD_*       - data-processing cmd codes the core decodes
//   COND_AL     - "always" condition code
//   *_LSB       - bit positions of fields inside an encoded 32-bit word
//   enc_t       - result of encode_instr(): legality flag plus packed word
package arm_isa_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10
  } op_e;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [3:0] COND_AL = 4'hE;

  localparam int unsigned COND_LSB  = 28;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_LSB = 20;
  localparam int unsigned BRL_LSB   = 24;
  localparam int unsigned RN_LSB    = 16;
  localparam int unsigned RD_LSB    = 12;
  localparam int unsigned SRC2_LSB  = 0;
  localparam int unsigned IMM24_LSB = 0;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  // Packs one field tuple; illegal tuples return legal=0 and a zero word.
  function automatic enc_t encode_instr(
    input logic [3:0]  cond,
    input logic [1:0]  op,
    input logic [5:0]  funct,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [11:0] src2,
    input logic [23:0] imm24
  );
    enc_t       r;
    logic [3:0] cmd;
    logic [5:0] f;
    logic [3:0] rd_e;
    r     = '0;
    cmd   = funct[4:1];
    f     = funct;
    rd_e  = rd;
    case (op_e'(op))
      OP_DP: begin
        r.legal = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
                  (cmd == CMD_ORR) || (cmd == CMD_CMP);
        // CMP only sets flags: S must be set and Rd is architecturally zero.
        if (cmd == CMD_CMP) begin
          f[0] = 1'b1;
          rd_e = '0;
        end
        r.word[COND_LSB +: 4]  = cond;
        r.word[OP_LSB +: 2]    = OP_DP;
        r.word[FUNCT_LSB +: 6] = f;
        r.word[RN_LSB +: 4]    = rn;
        r.word[RD_LSB +: 4]    = rd_e;
        r.word[SRC2_LSB +: 12] = src2;
      end
      OP_MEM: begin
        r.legal = 1'b1;
        r.word[COND_LSB +: 4]  = cond;
        r.word[OP_LSB +: 2]    = OP_MEM;
        r.word[FUNCT_LSB +: 6] = funct;
        r.word[RN_LSB +: 4]    = rn;
        r.word[RD_LSB +: 4]    = rd;
        r.word[SRC2_LSB +: 12] = src2;
      end
      OP_BR: begin
        r.legal = 1'b1;
        r.word[COND_LSB +: 4]   = cond;
        r.word[OP_LSB +: 2]     = OP_BR;
        r.word[BRL_LSB +: 2]    = 2'b10;
        r.word[IMM24_LSB +: 24] = imm24;
      end
      default: r = '0;
    endcase
    if (!r.legal) r.word = '0;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
//   clk, reset     - clock, synchronous active-high reset (empties the FIFO)
//   push, wdata    - write request/data; ignored when full
//   pop            - read request; ignored when empty
//   rdata          - current head entry (valid when !empty)
//   full, empty    - occupancy flags from the registered count
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  import arm_isa_pkg::*;

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   CNT_DEPTH = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_DEPTH);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs ARM-subset field tuples into machine words and loads
// them into instruction memory at sequential word addresses.
//   clk, reset               - clock, synchronous active-high reset
//   start                    - begin a load session (ignored while busy)
//   in_valid/in_ready/in_last- tuple handshake, in_last ends the session
//   in_cond..in_imm24        - instruction fields
//   mem_ready                - imem accepts the presented write
//   imem_we/addr/wd          - instruction-memory write port
//   busy, done, err          - session active, end pulse, sticky illegal flag
//   instr_count              - words written this session (saturating)
module instr_encoder
  import arm_isa_pkg::*;
#(
  parameter int unsigned    FIFO_DEPTH = 4,
  parameter int unsigned    AW         = 32,
  parameter logic [AW-1:0]  BASE_ADDR  = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [3:0]    in_cond,
  input  logic [1:0]    in_op,
  input  logic [5:0]    in_funct,
  input  logic [3:0]    in_rn,
  input  logic [3:0]    in_rd,
  input  logic [11:0]   in_src2,
  input  logic [23:0]   in_imm24,
  input  logic          mem_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   instr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROG,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          err_q;
  logic [15:0]   count_q;

  enc_t          enc;
  logic          accept, push, pop;
  logic          fifo_full, fifo_empty;
  logic [31:0]   fifo_rdata;

  assign enc    = encode_instr(in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_imm24);
  assign accept = in_valid && in_ready;
  assign push   = accept && enc.legal;
  assign pop    = imem_we && mem_ready;

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(enc.word),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PROG;
      S_PROG:  if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      // Nothing is ever buffered in IDLE, so session setup cannot collide with a pop.
      if (state_q == S_IDLE && start) begin
        addr_q  <= BASE_ADDR;
        err_q   <= 1'b0;
        count_q <= '0;
      end else begin
        if (accept && !enc.legal) err_q <= 1'b1;
        if (pop) begin
          addr_q <= addr_q + AW'(4);
          if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end
      end
    end
  end

  assign in_ready    = (state_q == S_PROG) && !fifo_full;
  assign imem_we     = !fifo_empty;
  assign imem_wd     = fifo_empty ? '0 : fifo_rdata;
  assign imem_addr   = addr_q;
  assign busy        = (state_q == S_PROG) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, in_last;
  logic [3:0]  in_cond, in_rn, in_rd;
  logic [1:0]  in_op;
  logic [5:0]  in_funct;
  logic [11:0] in_src2;
  logic [23:0] in_imm24;
  logic        mem_ready, imem_we, busy, done, err;
  logic [31:0] imem_addr, imem_wd;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  instr_encoder #(
    .FIFO_DEPTH(4),
    .AW        (32),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_cond    (in_cond),
    .in_op      (in_op),
    .in_funct   (in_funct),
    .in_rn      (in_rn),
    .in_rd      (in_rd),
    .in_src2    (in_src2),
    .in_imm24   (in_imm24),
    .mem_ready  (mem_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wd    (imem_wd),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .instr_count(instr_count)
  );

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } tup_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_addr;
  int unsigned exp_cnt;
  bit          exp_err;
  int unsigned done_cnt = 0;
  int unsigned mr_mode  = 0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_wd, prev_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model: legality and word value from the ISA rules.
  function automatic bit ref_legal(input tup_t t);
    int unsigned cmd = (int'(t.funct) / 2) % 16;
    if (t.op == 2'd3) return 1'b0;
    if (t.op != 2'd0) return 1'b1;
    return (cmd == 4) || (cmd == 2) || (cmd == 0) || (cmd == 12) || (cmd == 10);
  endfunction

  function automatic logic [31:0] ref_word(input tup_t t);
    int unsigned f   = t.funct;
    int unsigned rd  = t.rd;
    int unsigned cmd = (int'(t.funct) / 2) % 16;
    int unsigned w;
    if (t.op == 2'd2)
      return 32'(int'(t.cond) * 2**28 + 10 * 2**24 + int'(t.imm24));
    if (t.op == 2'd0 && cmd == 10) begin
      if (f % 2 == 0) f = f + 1;
      rd = 0;
    end
    w = t.cond * 2**28 + t.op * 2**26 + f * 2**20 + t.rn * 2**16 + rd * 2**12 + t.src2;
    return w;
  endfunction

  function automatic tup_t mk(input int unsigned c, input int unsigned o, input int unsigned fn,
                              input int unsigned n, input int unsigned d,
                              input int unsigned s2, input int unsigned i24);
    tup_t t;
    t.cond = 4'(c); t.op = 2'(o); t.funct = 6'(fn); t.rn = 4'(n);
    t.rd = 4'(d); t.src2 = 12'(s2); t.imm24 = 24'(i24);
    return t;
  endfunction

  function automatic tup_t rand_tup();
    int unsigned k = $urandom_range(0, 7);
    int unsigned o = (k < 3) ? 0 : (k < 5) ? 1 : (k < 7) ? 2 : 3;
    return mk($urandom_range(0, 15), o, $urandom_range(0, 63), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 4095), $urandom_range(0, 24'hFFFFFF));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory-side ready: 0 = always ready, 1 = stalled, otherwise random.
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = 1'b0;
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every completed write and checks
  // that a stalled write holds its data and address.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_we", {31'd0, imem_we}, 32'd1);
        check("hold_wd", imem_wd, prev_wd);
        check("hold_addr", imem_addr, prev_addr);
      end
      if (imem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_addr, imem_wd);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", imem_addr, mon_e.addr);
          check("wr_data", imem_wd, mon_e.word);
        end
      end
      prev_hold = imem_we && !mem_ready;
      prev_wd   = imem_wd;
      prev_addr = imem_addr;
    end
  end

  task automatic send(input tup_t t, input bit last, input int unsigned budget, output bit ok);
    in_cond = t.cond; in_op = t.op; in_funct = t.funct; in_rn = t.rn;
    in_rd = t.rd; in_src2 = t.src2; in_imm24 = t.imm24;
    in_last  = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        if (ref_legal(t)) begin
          exp_q.push_back('{exp_addr, ref_word(t)});
          exp_addr = exp_addr + 4;
          exp_cnt++;
        end else begin
          exp_err = 1'b1;
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic begin_session();
    exp_addr = 32'h0;
    exp_cnt  = 0;
    exp_err  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("start_err_clear", {31'd0, err}, 32'd0);
    check("start_count_clear", {16'd0, instr_count}, 32'd0);
    check("start_addr", imem_addr, 32'h0);
    step();
  endtask

  task automatic end_session(input int unsigned d0);
    bit got = 1'b0;
    for (int unsigned i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL done_timeout: got no done pulse, expected one within 300 cycles");
    end
    check("instr_count", {16'd0, instr_count}, exp_cnt);
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("queue_drained", exp_q.size(), 0);
    repeat (3) step();
    check("done_once", done_cnt - d0, 1);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_session(input tup_t ts[$], input int unsigned gap_max);
    int unsigned d0;
    bit ok;
    begin_session();
    d0 = done_cnt;
    foreach (ts[i]) begin
      repeat ($urandom_range(0, gap_max)) step();
      send(ts[i], i == ts.size() - 1, 50, ok);
      check("accepted", {31'd0, ok}, 32'd1);
    end
    end_session(d0);
  endtask

  initial begin : stim
    tup_t ts[$];
    tup_t add5;
    bit ok;
    int unsigned d0;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_cond = '0; in_op = '0; in_funct = '0; in_rn = '0; in_rd = '0;
    in_src2 = '0; in_imm24 = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wd", imem_wd, 32'h0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_count", {16'd0, instr_count}, 32'd0);
    step();
    reset = 1'b0;
    step();

    add5 = mk(4'hE, 0, 6'b101000, 2, 1, 12'h005, 0);
    check("model_add", ref_word(add5), 32'hE2821005);

    // ADD R1,R2,#5
    ts = '{add5};
    run_session(ts, 0);

    // CMP R0,#0 with S clear and Rd 7 offered
    ts = '{mk(4'hE, 0, 6'b110100, 0, 7, 0, 0)};
    check("model_cmp", ref_word(ts[0]), 32'hE3500000);
    run_session(ts, 0);

    // LDR R3,[R0,#8] then B -2
    ts = '{mk(4'hE, 1, 6'b011001, 0, 3, 12'h008, 0), mk(4'hE, 2, 0, 0, 0, 0, 24'hFFFFFE)};
    check("model_ldr", ref_word(ts[0]), 32'hE5903008);
    check("model_b", ref_word(ts[1]), 32'hEAFFFFFE);
    run_session(ts, 0);

    // Stalled memory: FIFO fills at 4, then drains on release.
    mr_mode = 1;
    step();
    begin_session();
    d0 = done_cnt;
    ts.delete();
    for (int unsigned i = 0; i < 6; i++)
      ts.push_back(mk(4'hE, 0, 6'b101000, i, i + 1, i * 3, 0));
    for (int unsigned i = 0; i < 4; i++) begin
      send(ts[i], 1'b0, 5, ok);
      check("fill_accept", {31'd0, ok}, 32'd1);
    end
    send(ts[4], 1'b0, 6, ok);
    check("full_blocked", {31'd0, ok}, 32'd0);
    @(negedge clk);
    check("full_ready_low", {31'd0, in_ready}, 32'd0);
    check("full_we", {31'd0, imem_we}, 32'd1);
    check("full_head", imem_wd, ref_word(ts[0]));
    check("full_addr", imem_addr, 32'h0);
    step();
    mr_mode = 0;
    send(ts[4], 1'b0, 20, ok);
    check("resume_accept", {31'd0, ok}, 32'd1);
    send(ts[5], 1'b1, 20, ok);
    check("resume_accept_last", {31'd0, ok}, 32'd1);
    end_session(d0);

    // Illegal op between two ADDs, then a fresh session clears err.
    ts = '{add5, mk(4'hE, 3, 6'b101000, 1, 1, 1, 0), mk(4'hE, 0, 6'b101000, 3, 4, 12'h0FF, 0)};
    run_session(ts, 1);
    check("illegal_err", {31'd0, err}, 32'd1);
    ts = '{mk(4'hE, 0, 6'b000000, 0, 0, 0, 0)};
    run_session(ts, 0);

    // Only illegal tuples: no writes, done still pulses.
    ts = '{mk(4'hE, 0, 6'b011110, 1, 2, 3, 0)};
    run_session(ts, 0);

    // Randomised sessions with random backpressure and gaps.
    mr_mode = 2;
    for (int unsigned s = 0; s < 20; s++) begin
      ts.delete();
      repeat ($urandom_range(1, 10)) ts.push_back(rand_tup());
      run_session(ts, 2);
    end
    mr_mode = 0;
    repeat (2) step();

    // Reset while in DRAIN with three buffered words.
    mr_mode = 1;
    step();
    begin_session();
    for (int unsigned i = 0; i < 3; i++) begin
      send(mk(4'hE, 1, 6'b011001, i, i, i * 4, 0), i == 2, 10, ok);
      check("drain_fill", {31'd0, ok}, 32'd1);
    end
    step();
    @(negedge clk);
    check("drain_busy", {31'd0, busy}, 32'd1);
    check("drain_we", {31'd0, imem_we}, 32'd1);
    step();
    d0 = done_cnt;
    reset = 1'b1;
    step();
    @(negedge clk);
    check("rst_mid_we", {31'd0, imem_we}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_addr", imem_addr, 32'h0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    step();
    reset = 1'b0;
    mr_mode = 0;
    repeat (4) step();
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_we_later", {31'd0, imem_we}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder and program loader for the single-cycle ARM-subset core.
- Accepts instruction fields (cond, op, funct, Rn, Rd, Src2/imm24) over a valid/ready stream and packs them into 32-bit ARM machine words.
- Validates each instruction against the subset the core decodes: ADD/SUB/AND/ORR/CMP, LDR/STR, B.
- Buffers the words in a small FIFO and writes them into instruction memory at sequential word addresses, with memory backpressure.

Parameters:
- FIFO_DEPTH, 4, number of encoded words buffered (power of two, ≥2)
- AW, 32, imem_addr width
- BASE_ADDR, 32'h0000_0000, first write address after start

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: begin a load session
- in_valid  in  1  field tuple valid
- in_ready  out  1  tuple accepted when in_valid & in_ready
- in_last  in  1  marks final tuple of session
- in_cond  in  4  condition field
- in_op  in  2  00 DP, 01 MEM, 10 B
- in_funct  in  6  DP {I,cmd[3:0],S} / MEM {~I,P,U,B,W,L}
- in_rn  in  4  Rn
- in_rd  in  4  Rd
- in_src2  in  12  Src2 / imm12
- in_imm24  in  24  branch offset
- mem_ready  in  1  imem accepts write this cycle
- imem_we  out  1  write request
- imem_addr  out  AW  byte address of write
- imem_wd  out  32  encoded word
- busy  out  1  session active
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky illegal-instruction flag
- instr_count  out  16  words written this session

Behaviour:
- Reset values: state IDLE, FIFO empty, imem_we=0, imem_addr=BASE_ADDR, imem_wd=0, in_ready=0, busy=0, done=0, err=0, instr_count=0.
- Reset mid-session discards all buffered words.
- State machine IDLE → PROG → DRAIN → DONE → IDLE:
  - IDLE: on start, clear err and instr_count, set addr=BASE_ADDR, go to PROG.
  - PROG: on accepted tuple with in_last=1, go to DRAIN.
  - DRAIN: when FIFO is empty, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored.
- busy=1 in PROG and DRAIN.
- in_ready = (state==PROG) & !fifo_full. Registered count; no push-on-full even if popping the same cycle.
- Encoding is combinational at acceptance:
  - DP: word = {cond, 2'b00, funct, rn, rd, src2}. For CMP (cmd 1010), S is forced to 1 and Rd to 0.
  - MEM: word = {cond, 2'b01, funct, rn, rd, src2}.
  - B: word = {cond, 2'b10, 2'b10, imm24}.
- Illegal tuples:
  - Conditions: op==11, or DP cmd not in {0100, 0010, 0000, 1100, 1010}.
  - Result: err←1, word not pushed, in_last still honoured.
- Write side:
  - imem_we = !fifo_empty; imem_wd = FIFO head; write completes when imem_we & mem_ready.
  - On each completed write: pop, imem_addr += 4 (wraps mod 2^AW), instr_count += 1 (saturates at 16'hFFFF).
  - imem_we/imem_wd hold stable while mem_ready=0.
- Latency: word accepted in cycle N is presented on imem_wd no earlier than N+1.
- Simultaneous push and pop in one cycle: count unchanged.
- Session with only illegal tuples: the FIFO stays empty; DRAIN is left on the next cycle and done still pulses.

Decomposition:
- Shared package arm_isa_pkg holds:
  - op enum (OP_DP, OP_MEM, OP_BR)
  - DP cmd constants (CMD_ADD 0100, CMD_SUB 0010, CMD_AND 0000, CMD_ORR 1100, CMD_CMP 1010)
  - cond constant COND_AL=4'hE
  - encoded-word field-position constants
- One sub-module, sync_fifo: parameterised width/depth; push/pop, full/empty, synchronous reset.

Test Plan:
- ADD R1,R2,#5 (cond E, op 00, funct 101000, rn 2, rd 1, src2 005, last) with mem_ready=1 → imem_wd=32'hE2821005 at addr 0, done pulse, instr_count=1.
- CMP R0,#0 given funct 110100, rd 7 → 32'hE3500000 (S forced, Rd zeroed).
- LDR R3,[R0,#8] (op 01, funct 011001, rn 0, rd 3, src2 008), then B -2 (op 10, imm24 FFFFFE, last) → writes E5903008 @0, EAFFFFFE @4.
- mem_ready=0 while 6 tuples are offered → exactly 4 accepted, in_ready=0, imem_we/wd stable. Release mem_ready → all 6 written at addrs 0..20, done once.
- Illegal op=11 tuple between two legal ADDs → err=1, only 2 words written at 0 and 4. A new start clears err.
- reset asserted in DRAIN with 3 buffered words → next cycle imem_we=0, busy=0, imem_addr=BASE_ADDR, no done pulse.
